// File: rtl/mvp_sync_pulse_pkg.sv
// Shared constants, arbiter state encoding and round-robin helper for mvp_sync_pulse_mc.
// Optional overflow flags are enabled by defining MVP_SYNC_PULSE_MC_OVF_EN.
package mvp_sync_pulse_pkg;

  localparam int unsigned MaxNumCh      = 16;
  localparam int unsigned MaxChW        = 4;
  localparam int unsigned MinSyncStages = 2;
  localparam int unsigned MaxSyncStages = 4;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  // First set request at or after ptr, wrapping at num_ch; 0 when nothing is requested.
  function automatic logic [MaxChW-1:0] rr_first(input logic [MaxNumCh-1:0] req,
                                                 input logic [MaxChW-1:0]   ptr,
                                                 input int unsigned         num_ch);
    logic [MaxChW-1:0] idx;
    rr_first = '0;
    for (int unsigned k = MaxNumCh; k > 0; k--) begin
      if (k <= num_ch) begin
        idx = MaxChW'((32'(ptr) + k - 1) % num_ch);
        if (req[idx]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mvp_sync_pulse_mc_ch.sv
// One event channel: toggle synchroniser, warm-up-gated edge detect, saturating event counter.
// Sticky overflow flag exists only when MVP_SYNC_PULSE_MC_OVF_EN is defined.
module mvp_sync_pulse_ch
  import mvp_sync_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle_in,
  input  logic warm_done,
  input  logic dec,
  input  logic ovf_clr,
  output logic pending,
  output logic ovf
);

  localparam int unsigned Stages = (SYNC_STAGES < MinSyncStages) ? MinSyncStages :
                                   (SYNC_STAGES > MaxSyncStages) ? MaxSyncStages : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [Stages-1:0] sync_q;
  logic              ref_q;
  logic              sync_out;
  logic              edge_det;
  logic              inc;
  logic              sat_drop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign sync_out = sync_q[Stages-1];
  assign edge_det = sync_out ^ ref_q;
  // The reference keeps tracking during warm-up so a level already high at reset is absorbed.
  assign inc      = edge_det & warm_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], toggle_in};
      ref_q  <= sync_out;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sat_drop = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CntMax) sat_drop = 1'b1;
      else                 cnt_d    = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign pending = |cnt_q;

`ifdef MVP_SYNC_PULSE_MC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= sat_drop | (ovf_q & ~ovf_clr);
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = sat_drop ^ ovf_clr;
  assign ovf        = 1'b0;
`endif

endmodule

// File: rtl/mvp_sync_pulse_mc.sv
// Multi-channel toggle-to-event receiver with a round-robin valid/ready event port.
// Define MVP_SYNC_PULSE_MC_OVF_EN to implement the sticky per-channel overflow flags.
module mvp_sync_pulse_mc
  import mvp_sync_pulse_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] toggle_in,
  output logic              evt_valid,
  output logic [CH_W-1:0]   evt_ch,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] ovf_clr
);

  localparam int unsigned   WarmCycles = SYNC_STAGES + 1;
  localparam int unsigned   WarmW      = $clog2(WarmCycles + 1);
  localparam logic [CH_W-1:0] LastCh   = CH_W'(NUM_CH - 1);

  logic [WarmW-1:0]    warm_q;
  logic                warm_done;
  logic                handshake;
  logic [NUM_CH-1:0]   dec;
  logic                any_pending;
  logic [MaxNumCh-1:0] req;
  logic [CH_W-1:0]     pick;
  arb_state_e          state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
    return (ch == LastCh) ? '0 : ch + CH_W'(1);
  endfunction

  assign warm_done = (warm_q == WarmW'(WarmCycles));

  always_ff @(posedge clk) begin
    if (reset)          warm_q <= '0;
    else if (!warm_done) warm_q <= warm_q + WarmW'(1);
  end

  assign handshake = evt_valid & evt_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    assign dec[i] = handshake && (evt_ch == CH_W'(i));

    mvp_sync_pulse_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .toggle_in(toggle_in[i]),
      .warm_done(warm_done),
      .dec      (dec[i]),
      .ovf_clr  (ovf_clr[i]),
      .pending  (pending[i]),
      .ovf      (ovf[i])
    );
  end

  assign any_pending = |pending;

  always_comb begin
    req              = '0;
    req[NUM_CH-1:0]  = pending;
    pick             = CH_W'(rr_first(req, MaxChW'(rr_ptr_q), NUM_CH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A grant accepted in its first cycle never locks, keeping one event per cycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          if (evt_ready) begin
            rr_ptr_d = wrap_inc(pick);
          end else begin
            state_d = StLocked;
            grant_d = pick;
          end
        end
      end
      StLocked: begin
        if (evt_ready) begin
          rr_ptr_d = wrap_inc(grant_q);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    evt_valid = 1'b0;
    evt_ch    = '0;
    unique case (state_q)
      StIdle: begin
        evt_valid = any_pending;
        evt_ch    = pick;
      end
      StLocked: begin
        evt_valid = 1'b1;
        evt_ch    = grant_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mvp_sync_pulse_mc.md
# mvp_sync_pulse_mc

Multi-channel toggle-to-event receiver for the MVP PLL control path. Each channel accepts a toggle-encoded event from a foreign clock domain, synchronises it into the `clk` domain through a parametrised flop chain, and converts every toggle edge into one counted event. Pending events are buffered per channel in saturating counters and delivered one at a time through a round-robin valid/ready port, so back-to-back events are never lost while the consumer stalls.

## Interface
- `NUM_CH`, 4: number of independent event channels (1..16).
- `SYNC_STAGES`, 2: synchroniser depth per channel (2..4).
- `CNT_W`, 3: pending-event counter width per channel; capacity `2^CNT_W-1`.
- `CH_W`, `$clog2(NUM_CH)` (min 1): derived, width of channel index.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `toggle_in`  in  NUM_CH  asynchronous toggle inputs; each level change is one event.
- `evt_valid`  out  1  an event is presented.
- `evt_ch`  out  CH_W  channel index of presented event.
- `evt_ready`  in  1  consumer accepts; handshake = `evt_valid & evt_ready`.
- `pending`  out  NUM_CH  per-channel counter non-zero.
- `ovf`  out  NUM_CH  sticky overflow flags (macro-gated).
- `ovf_clr`  in  NUM_CH  per-bit clear of `ovf` (macro-gated).

## Operation
- Reset values: all sync flops, edge-reference flops, counters, grant lock, RR pointer = 0; `evt_valid`=0, `evt_ch`=0, `pending`=0, `ovf`=0.
- Warm-up: after reset deasserts, a counter runs `SYNC_STAGES+1` cycles; during warm-up the edge-reference flop tracks the synchronised level but no events are counted (prevents a spurious event when `toggle_in` is already 1 at reset release).
- Edge detect: `edge[i] = sync_out[i] ^ ref[i]`; `ref[i] <= sync_out[i]` every cycle.
- Counter per channel: +1 on edge, -1 on handshake for that channel, unchanged when both occur in one cycle; saturates at `2^CNT_W-1`; an edge arriving at saturation is dropped and sets `ovf[i]`.
- Arbitration states: IDLE (no lock) and LOCKED. In IDLE, if any `pending`, grant the first pending channel at or after the RR pointer, drive `evt_valid`=1, `evt_ch`=grant, enter LOCKED. In LOCKED, `evt_ch` held stable until handshake; on handshake the pointer becomes `grant+1` (wraps at `NUM_CH-1`→0) and the state returns to IDLE; the next grant is selectable in the same cycle (no bubble).
- `evt_valid` never deasserts without a handshake except on `reset`.
- Reset mid-operation: all pending events are discarded; no event is emitted until warm-up completes.

## Timing
- Toggle stable before edge k → synchronised at edge k+SYNC_STAGES-1 → counter increments at edge k+SYNC_STAGES → `evt_valid` high after that edge (latency SYNC_STAGES+1 cycles, default 3).
- Handshake at edge n on a counter of 1 → `pending[i]` low after edge n.
- Sustained throughput: one event per cycle with `evt_ready` held high.
- `toggle_in` must hold each level ≥ SYNC_STAGES+1 `clk` cycles; faster toggling is out of contract.

## Configuration
- `MVP_SYNC_PULSE_MC_OVF_EN` defined: `ovf` sticky flags implemented; `ovf_clr[i]` clears bit i; set wins over clear in the same cycle.
- Undefined: `ovf` tied to 0, `ovf_clr` ignored; saturation drops still occur silently.

## Structure
- Package `mvp_sync_pulse_pkg`: max `NUM_CH` (16), min/max `SYNC_STAGES`, arbiter state encoding (IDLE/LOCKED).
- Sub-module `mvp_sync_pulse_ch`: one channel's sync chain, warm-up-gated edge detect, saturating counter, overflow flag; top instantiates `NUM_CH` copies plus the round-robin arbiter.

## Test plan
- Reset with `toggle_in`=4'b0101 held, then release → no `evt_valid` ever; `pending`=0.
- Single toggle ch2, `evt_ready`=1 → `evt_valid`=1, `evt_ch`=2 exactly SYNC_STAGES+1 cycles later, one cycle only.
- 5 toggles on ch1 with `evt_ready`=0, CNT_W=3 → counter 5; then ready=1 → exactly 5 handshakes, `evt_ch`=1.
- Simultaneous single events on ch0..ch3, ready=1 → handshakes in order 0,1,2,3; second round starting after pointer=1 grants ch1 before ch0.
- 9 toggles on ch3, ready=0, macro on → counter 7, `ovf[3]`=1; `ovf_clr[3]` pulse → `ovf[3]`=0; macro off → `ovf`=0 throughout.
- `evt_valid` held with ready=0 while a lower-index channel becomes pending → `evt_ch` unchanged until handshake; assert `reset` mid-stall → `evt_valid`=0 next cycle, all counters 0.
